peridot_spi_flashread_seq: RTL and testbench

Autonomous SPI-flash read sequencer that sits directly upstream of the PERIDOT host-bridge SPI master CSR block and drives it over its two-register Avalon-MM slave port. A host programs a flash byte address and a length, and the block issues the READ command, address bytes and dummy transfers, then streams the received bytes out on an Avalon-ST source. Typical uses are boot-image or configuration fetch without CPU byte-polling.

---
 rtl/peridot_flashread_pkg.sv | 55 +++++
 rtl/peridot_spi_flashread_seq_if.sv | 34 +++
 rtl/peridot_flashread_csr.sv | 73 +++++++
 rtl/peridot_spi_flashread_seq.sv | 165 ++++++++++++++++
 tb/tb_peridot_spi_flashread_seq.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/peridot_flashread_pkg.sv
// Shared types and constants for the PERIDOT SPI flash read sequencer.
// Build option: PERIDOT_FLASHREAD_FASTREAD_EN selects FAST READ (0x0B plus one dummy byte).
package peridot_flashread_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG,
        ST_WAIT_SEND,
        ST_SEND,
        ST_WAIT_POLL,
        ST_POLL_A,
        ST_POLL_B,
        ST_PUSH,
        ST_RELEASE,
        ST_DONE
    } seq_state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

`ifdef PERIDOT_FLASHREAD_FASTREAD_EN
    localparam logic [7:0] READ_CMD  = CMD_FAST_READ;
    localparam logic [2:0] CMD_BYTES = 3'd5;
`else
    localparam logic [7:0] READ_CMD  = CMD_READ;
    localparam logic [2:0] CMD_BYTES = 3'd4;
`endif

    localparam int SPI_START_BIT  = 9;
    localparam int SPI_SELECT_BIT = 8;
    localparam int SPI_READY_BIT  = 9;
    localparam int SPI_DEVSEL_LSB = 10;
    localparam int SPI_DEVSEL_MSB = 14;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_ADDR = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQENA_BIT = 1;
    localparam int CTRL_DONE_BIT   = 2;

    function automatic logic [31:0] spi_ctrl_word(input logic [4:0] devsel, input logic start,
                                                  input logic sel, input logic [7:0] tx);
        logic [31:0] w;
        w = '0;
        w[SPI_DEVSEL_MSB:SPI_DEVSEL_LSB] = devsel;
        w[SPI_START_BIT]  = start;
        w[SPI_SELECT_BIT] = sel;
        w[7:0] = tx;
        return w;
    endfunction

endpackage

// File: rtl/peridot_spi_flashread_seq_if.sv
// Bus bundle for the flash read sequencer: host CSR slave, SPI master port, stream source, irq.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface peridot_spi_flashread_seq_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        ins_irq;

    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;

    logic [7:0]  aso_data;
    logic        aso_valid;
    logic        aso_ready;
    logic        aso_startofpacket;
    logic        aso_endofpacket;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avm_readdata, aso_ready,
        output avs_readdata, ins_irq, avm_address, avm_read, avm_write, avm_writedata,
        output aso_data, aso_valid, aso_startofpacket, aso_endofpacket
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avm_readdata, aso_ready,
        input  avs_readdata, ins_irq, avm_address, avm_read, avm_write, avm_writedata,
        input  aso_data, aso_valid, aso_startofpacket, aso_endofpacket
    );
endinterface

// File: rtl/peridot_flashread_csr.sv
// Host register file: start/busy handshake, done W1C flag, irq enable, address/length latches.
module peridot_flashread_csr
    import peridot_flashread_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [23:0] writedata,
    input  logic        done_set,
    output logic        start,
    output logic [23:0] seq_addr,
    output logic [15:0] seq_len,
    output logic        irq
);

    logic        busy;
    logic        done;
    logic        irqena;
    logic [23:0] addr_reg;
    logic [15:0] len_reg;
    logic        ctrl_wr;

    assign ctrl_wr = write && (address == REG_CTRL);
    assign start   = ctrl_wr && writedata[CTRL_START_BIT] && !busy;
    assign irq     = irqena && done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            irqena   <= 1'b0;
            addr_reg <= '0;
            len_reg  <= '0;
            seq_addr <= '0;
            seq_len  <= '0;
        end else begin
            if (ctrl_wr)
                irqena <= writedata[CTRL_IRQENA_BIT];
            if (write && (address == REG_ADDR) && !busy)
                addr_reg <= writedata[23:0];
            if (write && (address == REG_LEN) && !busy)
                len_reg <= writedata[15:0];
            if (start) begin
                busy     <= 1'b1;
                seq_addr <= addr_reg;
                seq_len  <= len_reg;
            end else if (done_set) begin
                busy <= 1'b0;
            end
            // A completion in the same cycle as a host W1C keeps done set.
            if (done_set)
                done <= 1'b1;
            else if (ctrl_wr && writedata[CTRL_DONE_BIT])
                done <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        if (read) begin
            case (address)
                REG_CTRL: readdata = {29'd0, done, irqena, busy};
                REG_ADDR: readdata = {8'd0, addr_reg};
                REG_LEN:  readdata = {16'd0, len_reg};
                default:  readdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/peridot_spi_flashread_seq.sv
// Autonomous SPI-flash read sequencer driving the PERIDOT SPI master CSR port and an Avalon-ST source.
// Build option: PERIDOT_FLASHREAD_FASTREAD_EN switches to FAST READ with one discarded dummy byte.
module peridot_spi_flashread_seq
    import peridot_flashread_pkg::*;
#(
    parameter int unsigned DEVSEL = 0,
    parameter int unsigned CLKDIV = 1
) (
    input logic                        csi_clk,
    input logic                        rsi_reset,
    peridot_spi_flashread_seq_if.slave bus
);

    seq_state_t  state;
    seq_state_t  state_nx;
    logic        start;
    logic        done_set;
    logic [23:0] seq_addr;
    logic [15:0] seq_len;
    logic [2:0]  cmd_cnt;
    logic        data_byte;
    logic [16:0] remaining;
    logic        first_beat;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        spi_ready;
    logic        avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        aso_valid;
    logic        unused_bits;

    localparam logic [4:0] DEVSEL_F = 5'(DEVSEL);
    localparam logic [7:0] CLKDIV_F = 8'(CLKDIV);

    assign unused_bits = ^{bus.avs_writedata[31:24], bus.avm_readdata[31:10], bus.avm_readdata[8]};
    assign spi_ready   = bus.avm_readdata[SPI_READY_BIT];

    peridot_flashread_csr u_csr (
        .clk       (csi_clk),
        .rst       (rsi_reset),
        .address   (bus.avs_address),
        .read      (bus.avs_read),
        .readdata  (bus.avs_readdata),
        .write     (bus.avs_write),
        .writedata (bus.avs_writedata[23:0]),
        .done_set  (done_set),
        .start     (start),
        .seq_addr  (seq_addr),
        .seq_len   (seq_len),
        .irq       (bus.ins_irq)
    );

    always_comb begin
        case (cmd_cnt)
            3'd0:    tx_byte = READ_CMD;
            3'd1:    tx_byte = seq_addr[23:16];
            3'd2:    tx_byte = seq_addr[15:8];
            3'd3:    tx_byte = seq_addr[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state      <= ST_IDLE;
            cmd_cnt    <= '0;
            data_byte  <= 1'b0;
            remaining  <= '0;
            first_beat <= 1'b0;
            rx_byte    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_CFG: begin
                    cmd_cnt    <= '0;
                    first_beat <= 1'b1;
                    remaining  <= (seq_len == 16'd0) ? 17'h1_0000 : {1'b0, seq_len};
                end
                // Bytes past the command/address/dummy prefix are data bytes.
                ST_SEND: begin
                    data_byte <= (cmd_cnt == CMD_BYTES);
                    if (cmd_cnt != CMD_BYTES)
                        cmd_cnt <= cmd_cnt + 3'd1;
                end
                ST_POLL_B: begin
                    if (spi_ready && data_byte)
                        rx_byte <= bus.avm_readdata[7:0];
                end
                ST_PUSH: begin
                    if (bus.aso_ready) begin
                        remaining  <= remaining - 17'd1;
                        first_beat <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        avm_address   = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        aso_valid     = 1'b0;
        done_set      = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nx = ST_CFG;
            ST_CFG: begin
                avm_address   = 1'b1;
                avm_write     = 1'b1;
                avm_writedata = {24'd0, CLKDIV_F};
                state_nx      = ST_WAIT_SEND;
            end
            ST_WAIT_SEND: state_nx = ST_SEND;
            ST_SEND: begin
                avm_write     = 1'b1;
                avm_writedata = spi_ctrl_word(DEVSEL_F, 1'b1, 1'b1, tx_byte);
                state_nx      = ST_WAIT_POLL;
            end
            ST_WAIT_POLL: state_nx = ST_POLL_A;
            ST_POLL_A: begin
                avm_read = 1'b1;
                state_nx = ST_POLL_B;
            end
            ST_POLL_B: begin
                avm_read = 1'b1;
                if (!spi_ready)
                    state_nx = ST_WAIT_POLL;
                else if (data_byte)
                    state_nx = ST_PUSH;
                else
                    state_nx = ST_WAIT_SEND;
            end
            ST_PUSH: begin
                aso_valid = 1'b1;
                if (bus.aso_ready)
                    state_nx = (remaining == 17'd1) ? ST_RELEASE : ST_SEND;
            end
            ST_RELEASE: begin
                avm_write     = 1'b1;
                avm_writedata = spi_ctrl_word(DEVSEL_F, 1'b0, 1'b0, 8'h00);
                state_nx      = ST_DONE;
            end
            ST_DONE: begin
                done_set = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.avm_address       = avm_address;
    assign bus.avm_read          = avm_read;
    assign bus.avm_write         = avm_write;
    assign bus.avm_writedata     = avm_writedata;
    assign bus.aso_valid         = aso_valid;
    assign bus.aso_data          = rx_byte;
    assign bus.aso_startofpacket = aso_valid && first_beat;
    assign bus.aso_endofpacket   = aso_valid && (remaining == 17'd1);

endmodule

// File: tb/tb_peridot_spi_flashread_seq.sv
// Directed bench for peridot_spi_flashread_seq with an SPI-master + flash behavioural model.
`timescale 1ns/1ps
module tb_peridot_spi_flashread_seq;

`ifdef PERIDOT_FLASHREAD_FASTREAD_EN
    localparam logic [7:0] TB_CMD  = 8'h0B;
    localparam int         TB_NCMD = 5;
`else
    localparam logic [7:0] TB_CMD  = 8'h03;
    localparam int         TB_NCMD = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    peridot_spi_flashread_seq_if bus();

    peridot_spi_flashread_seq #(.DEVSEL(5), .CLKDIV(1)) dut (
        .csi_clk   (clk),
        .rsi_reset (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // SPI master + flash model: flash byte at address a is a[7:0] ^ 0xA5.
    logic [7:0]  txq[$];
    logic [9:0]  sq[$];
    int          busy_cnt;
    logic [7:0]  spi_rx;
    int          byte_idx;
    logic [23:0] addr_acc;
    logic [31:0] cfg_word;
    logic [31:0] rel_word;
    logic [31:0] first_send;
    int          wr_cnt    = 0;
    int          proto_err = 0;
    logic        prev_act;
    logic        prev_rd;
    int          rd_len;

    assign bus.avm_readdata = {22'd0, (busy_cnt == 0), 1'b0, spi_rx};

    always @(posedge clk or posedge rst) begin : spi_model
        logic [23:0] fa;
        logic        bad;
        if (rst) begin
            busy_cnt <= 0;
            spi_rx   <= 8'h00;
            byte_idx <= 0;
            addr_acc <= 24'h0;
            prev_act <= 1'b0;
            prev_rd  <= 1'b0;
            rd_len   <= 0;
        end else begin
            bad = 1'b0;
            if (bus.avm_read && bus.avm_write) bad = 1'b1;
            if (bus.avm_write && prev_act) bad = 1'b1;
            if (bus.avm_read && !prev_rd && prev_act) bad = 1'b1;
            if (bus.avm_read && rd_len >= 2) bad = 1'b1;
            if (!bus.avm_read && prev_rd && rd_len != 2) bad = 1'b1;
            if (bad) proto_err <= proto_err + 1;
            prev_act <= bus.avm_read | bus.avm_write;
            prev_rd  <= bus.avm_read;
            rd_len   <= bus.avm_read ? rd_len + 1 : 0;
            if (bus.avm_write) begin
                wr_cnt <= wr_cnt + 1;
                if (bus.avm_address) begin
                    cfg_word <= bus.avm_writedata;
                end else if (bus.avm_writedata[9]) begin
                    txq.push_back(bus.avm_writedata[7:0]);
                    if (byte_idx == 0) first_send <= bus.avm_writedata;
                    if (byte_idx == 1) addr_acc[23:16] <= bus.avm_writedata[7:0];
                    if (byte_idx == 2) addr_acc[15:8]  <= bus.avm_writedata[7:0];
                    if (byte_idx == 3) addr_acc[7:0]   <= bus.avm_writedata[7:0];
                    fa = addr_acc + 24'(byte_idx - TB_NCMD);
                    spi_rx   <= (byte_idx < TB_NCMD) ? 8'hEE : (fa[7:0] ^ 8'hA5);
                    byte_idx <= byte_idx + 1;
                    busy_cnt <= 3;
                end else if (!bus.avm_writedata[8]) begin
                    rel_word <= bus.avm_writedata;
                    byte_idx <= 0;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.aso_valid && bus.aso_ready)
            sq.push_back({bus.aso_startofpacket, bus.aso_endofpacket, bus.aso_data});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        #1 d = bus.avs_readdata;
        bus.avs_read = 1'b0;
    endtask

    task automatic start_op(input logic [23:0] a, input logic [15:0] len, input logic irqena);
        avs_wr(2'd1, {8'd0, a});
        avs_wr(2'd2, {16'd0, len});
        @(negedge clk);
        bus.avs_address   = 2'd0;
        bus.avs_writedata = {29'd0, 1'b1, irqena, 1'b1};
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
        check_eq("cfg_latency", {30'd0, bus.avm_write, bus.avm_address}, 32'd3);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        logic        ok;
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 3000; i++) begin
            avs_rd(2'd0, d);
            if (d[2]) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done"}, {31'd0, ok}, 32'd1);
        check_eq({tag, "_busy_clr"}, {31'd0, d[0]}, 32'd0);
    endtask

    task automatic check_tx(input string tag, input logic [23:0] a, input int n);
        logic [7:0] e;
        check_eq({tag, "_txlen"}, txq.size(), TB_NCMD + n);
        for (int i = 0; i < txq.size() && i < TB_NCMD + n; i++) begin
            case (i)
                0:       e = TB_CMD;
                1:       e = a[23:16];
                2:       e = a[15:8];
                3:       e = a[7:0];
                default: e = 8'h00;
            endcase
            check_eq($sformatf("%s_tx%0d", tag, i), {24'd0, txq[i]}, {24'd0, e});
        end
    endtask

    task automatic check_beat(input string tag, input int i, input logic sop, input logic eop,
                              input logic [7:0] data);
        logic [31:0] got;
        got = (i < sq.size()) ? {22'd0, sq[i]} : 32'hDEAD_BEEF;
        check_eq($sformatf("%s_beat%0d", tag, i), got, {22'd0, sop, eop, data});
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sq.size() >= n) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  held;
        int          w0;
        int          stable_bad;

        bus.avs_address   = 2'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.aso_ready     = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_avm_write", {31'd0, bus.avm_write}, 32'd0);
        check_eq("rst_avm_read", {31'd0, bus.avm_read}, 32'd0);
        check_eq("rst_avm_wdata", bus.avm_writedata, 32'd0);
        check_eq("rst_aso_valid", {31'd0, bus.aso_valid}, 32'd0);
        check_eq("rst_aso_data", {24'd0, bus.aso_data}, 32'd0);
        check_eq("rst_sop_eop", {30'd0, bus.aso_startofpacket, bus.aso_endofpacket}, 32'd0);
        check_eq("rst_irq", {31'd0, bus.ins_irq}, 32'd0);
        rst = 1'b0;
        avs_rd(2'd0, d); check_eq("rst_reg0", d, 32'd0);
        avs_rd(2'd1, d); check_eq("rst_reg1", d, 32'd0);
        avs_rd(2'd2, d); check_eq("rst_reg2", d, 32'd0);

        // Length 4 at 0x123456
        txq.delete(); sq.delete();
        start_op(24'h123456, 16'd4, 1'b0);
        wait_done("t1");
        check_tx("t1", 24'h123456, 4);
        check_eq("t1_nbeats", sq.size(), 4);
        check_beat("t1", 0, 1'b1, 1'b0, 8'hF3);
        check_beat("t1", 1, 1'b0, 1'b0, 8'hF2);
        check_beat("t1", 2, 1'b0, 1'b0, 8'hFD);
        check_beat("t1", 3, 1'b0, 1'b1, 8'hFC);
        check_eq("t1_cfg_word", cfg_word, 32'h0000_0001);
        check_eq("t1_first_send", first_send, 32'h0000_1700 | {24'd0, TB_CMD});
        check_eq("t1_release", rel_word, 32'h0000_1400);
        check_eq("t1_irq_off", {31'd0, bus.ins_irq}, 32'd0);
        avs_rd(2'd3, d); check_eq("reg3_zero", d, 32'd0);

        // Length 1 at top of address space, irq enabled
        txq.delete(); sq.delete();
        start_op(24'hFFFFFF, 16'd1, 1'b1);
        wait_done("t2");
        check_tx("t2", 24'hFFFFFF, 1);
        check_eq("t2_nbeats", sq.size(), 1);
        check_beat("t2", 0, 1'b1, 1'b1, 8'h5A);
        check_eq("t2_irq_on", {31'd0, bus.ins_irq}, 32'd1);
        avs_wr(2'd0, 32'h0000_0006);
        check_eq("t2_irq_w1c", {31'd0, bus.ins_irq}, 32'd0);
        avs_rd(2'd0, d); check_eq("t2_reg0_w1c", d, 32'h0000_0002);

        // Backpressure on the second beat
        txq.delete(); sq.delete();
        start_op(24'h000010, 16'd3, 1'b0);
        wait_beats(1);
        bus.aso_ready = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.aso_valid) break;
            @(negedge clk);
        end
        held = bus.aso_data;
        w0 = wr_cnt;
        stable_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.aso_data !== held || bus.aso_valid !== 1'b1) stable_bad++;
        end
        check_eq("t3_held_data", {24'd0, held}, 32'h0000_00B4);
        check_eq("t3_stable", stable_bad, 0);
        check_eq("t3_no_write", wr_cnt, w0);
        bus.aso_ready = 1'b1;
        wait_done("t3");
        check_eq("t3_nbeats", sq.size(), 3);
        check_beat("t3", 0, 1'b1, 1'b0, 8'hB5);
        check_beat("t3", 1, 1'b0, 1'b0, 8'hB4);
        check_beat("t3", 2, 1'b0, 1'b1, 8'hB7);

        // Writes while busy are ignored
        txq.delete(); sq.delete();
        start_op(24'h000100, 16'd2, 1'b0);
        avs_wr(2'd1, 32'h00AB_CDEF);
        avs_wr(2'd2, 32'h0000_0007);
        avs_wr(2'd0, 32'h0000_0001);
        avs_rd(2'd1, d); check_eq("t4_addr_kept", d, 32'h0000_0100);
        avs_rd(2'd2, d); check_eq("t4_len_kept", d, 32'h0000_0002);
        wait_done("t4");
        repeat (5) @(negedge clk);
        avs_rd(2'd0, d); check_eq("t4_no_restart", {31'd0, d[0]}, 32'd0);
        check_tx("t4", 24'h000100, 2);
        check_eq("t4_nbeats", sq.size(), 2);
        check_beat("t4", 0, 1'b1, 1'b0, 8'hA5);
        check_beat("t4", 1, 1'b0, 1'b1, 8'hA4);

        // Asynchronous reset during the data phase
        txq.delete(); sq.delete();
        start_op(24'h123456, 16'd4, 1'b1);
        wait_beats(1);
        check_eq("t5_pre_data", {24'd0, bus.aso_data}, 32'h0000_00F3);
        @(negedge clk);
        #2 rst = 1'b1;
        bus.avs_address = 2'd0;
        bus.avs_read    = 1'b1;
        #1;
        check_eq("t5_rst_reg0", bus.avs_readdata, 32'd0);
        check_eq("t5_rst_aso_data", {24'd0, bus.aso_data}, 32'd0);
        check_eq("t5_rst_ctrl", {28'd0, bus.avm_write, bus.avm_read, bus.aso_valid, bus.ins_irq}, 32'd0);
        check_eq("t5_rst_wdata", bus.avm_writedata, 32'd0);
        bus.avs_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        txq.delete(); sq.delete();
        start_op(24'h000000, 16'd1, 1'b0);
        wait_done("t5");
        check_tx("t5", 24'h000000, 1);
        check_eq("t5_nbeats", sq.size(), 1);
        check_beat("t5", 0, 1'b1, 1'b1, 8'hA5);

        check_eq("avm_protocol", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
